// File: rtl/pipe_reg_skid.sv
// Elastic pipeline register with a skid entry.
// The main entry drives the output. The skid entry catches the one word that
// arrives while downstream stalls. Because of this, upstream ready comes
// straight from a flop and does not depend on out_ready.
module pipe_reg_skid #(
  parameter int W        = 32,
  parameter int CLR_DATA = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occ
);

  logic         main_v_q, main_v_d;
  logic         skid_v_q, skid_v_d;
  logic [W-1:0] main_data_q, main_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         acc;
  logic         emit;
  logic         clear;

  // Handshake events are derived only from registered state and the inputs
  assign acc   = in_valid & ~skid_v_q;
  assign emit  = main_v_q & out_ready;
  assign clear = ~rstn | flush;

  // Outputs are taken straight from the registers
  assign in_ready  = ~skid_v_q;
  assign out_valid = main_v_q;
  assign out_data  = main_data_q;
  assign occ       = {main_v_q & skid_v_q, main_v_q ^ skid_v_q};

  // Next-state selection: squash, or the load, skid and drain moves of the two entries
  always_comb begin
    main_v_d    = main_v_q;
    skid_v_d    = skid_v_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (clear) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      if (CLR_DATA != 0) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      case ({main_v_q, skid_v_q})
        2'b00: begin
          if (acc) begin
            main_v_d    = 1'b1;
            main_data_d = in_data;
          end
        end
        2'b10: begin
          if (acc && emit) begin
            main_data_d = in_data;
          end else if (acc) begin
            skid_v_d    = 1'b1;
            skid_data_d = in_data;
          end else if (emit) begin
            main_v_d = 1'b0;
          end
        end
        2'b11: begin
          if (emit) begin
            main_data_d = skid_data_q;
            skid_v_d    = 1'b0;
          end
        end
        default: begin
          main_v_d = main_v_q;
        end
      endcase
    end
  end

  // State registers; reset and flush are both folded into the next-state logic
  always_ff @(posedge clk) begin
    main_v_q    <= main_v_d;
    skid_v_q    <= skid_v_d;
    main_data_q <= main_data_d;
    skid_data_q <= skid_data_d;
  end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Bench for pipe_reg_skid. It drives two instances: a 32-bit one that clears
// its data, and a 1-bit one that keeps its data. Each instance is checked
// against a queue model of a two-deep FIFO.
module tb_pipe_reg_skid;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  occ;

  logic        in_valid1 = 1'b0;
  logic        in_ready1;
  logic [0:0]  in_data1 = '0;
  logic        out_valid1;
  logic        out_ready1 = 1'b0;
  logic [0:0]  out_data1;
  logic [1:0]  occ1;

  logic [31:0] q0[$];
  logic        q1[$];
  bit          stall0, stall1;
  logic [31:0] head0;
  logic        head1;

  int nChecks = 0;
  int nFails  = 0;

  // Free-running clock
  always #5 clk = ~clk;

  pipe_reg_skid #(.W(32), .CLR_DATA(1)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occ(occ)
  );

  pipe_reg_skid #(.W(1), .CLR_DATA(0)) dut1 (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .occ(occ1)
  );

  // Single comparison point: counts the check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compares both instances with their FIFO models
  task automatic compareModels();
    checkOutput("out_valid", 32'(out_valid), 32'(q0.size() > 0));
    checkOutput("occ", 32'(occ), 32'(q0.size()));
    checkOutput("in_ready", 32'(in_ready), 32'(q0.size() < 2));
    if (q0.size() > 0) checkOutput("out_data", out_data, q0[0]);
    if (stall0) checkOutput("stable", out_data, head0);
    checkOutput("w1_out_valid", 32'(out_valid1), 32'(q1.size() > 0));
    checkOutput("w1_occ", 32'(occ1), 32'(q1.size()));
    checkOutput("w1_in_ready", 32'(in_ready1), 32'(q1.size() < 2));
    if (q1.size() > 0) checkOutput("w1_out_data", 32'(out_data1), 32'(q1[0]));
    if (stall1) checkOutput("w1_stable", 32'(out_data1), 32'(head1));
  endtask

  // Drives one cycle on both instances, advances the models, then checks after the edge
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r,
                               input logic v1, input logic d1, input logic r1,
                               input logic fl, input logic rst);
    bit clr, a, e;
    in_valid   = v;
    in_data    = d;
    out_ready  = r;
    in_valid1  = v1;
    in_data1   = d1;
    out_ready1 = r1;
    flush      = fl;
    rstn       = ~rst;
    clr = rst | fl;

    a = v && (q0.size() < 2);
    e = (q0.size() > 0) && r;
    stall0 = (q0.size() > 0) && !r && !clr;
    head0  = (q0.size() > 0) ? q0[0] : 32'h0;
    if (clr) q0.delete();
    else begin
      if (e) void'(q0.pop_front());
      if (a) q0.push_back(d);
    end

    a = v1 && (q1.size() < 2);
    e = (q1.size() > 0) && r1;
    stall1 = (q1.size() > 0) && !r1 && !clr;
    head1  = (q1.size() > 0) ? q1[0] : 1'b0;
    if (clr) q1.delete();
    else begin
      if (e) void'(q1.pop_front());
      if (a) q1.push_back(d1);
    end

    @(posedge clk);
    @(negedge clk);
    compareModels();
  endtask

  // Directed scenarios first, then randomised backpressure
  initial begin
    // Reset held for two cycles while a word is offered
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_occ", 32'(occ), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_out_valid", 32'(out_valid), 32'd0);

    // Streaming with downstream always ready
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 32'(k), 1'b1, 1'b1, k[0], 1'b1, 1'b0, 1'b0);
      checkOutput("stream_data", out_data, 32'(k));
      checkOutput("stream_occ", 32'(occ), 32'd1);
      checkOutput("stream_in_ready", 32'(in_ready), 32'd1);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("stream_drain_occ", 32'(occ), 32'd0);

    // Stall fills the skid entry, then release drains in order
    applyStimulus(1'b1, 32'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hB, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("skid_occ", 32'(occ), 32'd2);
    checkOutput("skid_in_ready", 32'(in_ready), 32'd0);
    checkOutput("skid_hold", out_data, 32'hA);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("drain_first", out_data, 32'hB);
    checkOutput("drain_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("drain_empty", 32'(occ), 32'd0);

    // Flush with a full stage and a word offered in the same cycle
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_flush_occ", 32'(occ), 32'd2);
    applyStimulus(1'b1, 32'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_occ", 32'(occ), 32'd0);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("flush_no_55", 32'(out_valid), 32'd0);

    // Simultaneous accept and emit with one entry held
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ae_first", out_data, 32'h10);
    applyStimulus(1'b1, 32'h20, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("ae_data", out_data, 32'h20);
    checkOutput("ae_occ", 32'(occ), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomised traffic with occasional flush and reset
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 199) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/pipe_reg_skid.md
Name: pipe_reg_skid

Overview:
- Parametrised elastic pipeline register for the core pipeline. It replaces the plain enable/clear flip-flop stage with a valid/ready handshake.
- Holds one main entry plus one skid entry, so upstream ready is a pure register output. This breaks the combinational ready path between stages and still sustains one transfer per cycle.
- A synchronous flush squashes both entries for branch mispredict and trap handling.

Parameters:
- W, 32, payload width in bits (W >= 1).
- CLR_DATA, 1, 1 = reset/flush also zero the data registers; 0 = only valid bits are cleared and data registers hold their contents.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  synchronous reset, active-low.
- flush  input  1  synchronous squash; clears both entries.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  stage can accept a word this cycle.
- in_data  input  W  upstream payload.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  W  payload of the main entry.
- occ  output  2  occupancy: 0, 1 or 2 entries.

Behaviour:
- State:
  - main_v / main_d: the output entry. out_valid = main_v, out_data = main_d.
  - skid_v / skid_d: overflow entry.
  - occ = main_v + skid_v.
  - Invariant: skid_v = 1 implies main_v = 1.
- in_ready = ~skid_v, driven only by a register, with no combinational path from out_ready or in_valid.
- Events: acc = in_valid & in_ready; emit = main_v & out_ready.
- Reset (rstn = 0, synchronous):
  - main_v = 0, skid_v = 0.
  - main_d and skid_d = 0 when CLR_DATA = 1.
  - Results after the edge: out_valid 0, in_ready 1, occ 0, out_data 0 (CLR_DATA = 1).
  - Reset during a transfer discards both entries; no partial state survives.
- Flush (rstn = 1, flush = 1): identical to reset. Flush has priority over acc and emit in the same cycle.
  - A word offered in a flush cycle is dropped even though in_ready may read 1.
  - A word emitted in a flush cycle counts as delivered to downstream.
- Normal update, evaluated on the registered state (pairs are main_v, skid_v):
  - (0,0), acc: main <= in. Result (1,0).
  - (1,0), acc & emit: main <= in. Result stays (1,0).
  - (1,0), acc & ~emit: skid <= in. Result (1,1); in_ready drops next cycle.
  - (1,0), ~acc & emit: main_v <= 0. Result (0,0).
  - (1,1), emit: main <= skid, skid_v <= 0. Result (1,0). No accept is possible in this state.
  - (1,1), ~emit: hold everything.
  - Any other combination: hold.
- Latency and throughput:
  - Latency from acc to out_valid is 1 cycle.
  - With out_ready held at 1, throughput is 1 word per cycle with no bubbles.
  - After a stall releases, the skid entry drains first and in_ready returns 1 one cycle later.
- Ordering: strict FIFO. No word is duplicated or lost except through reset/flush.
- Data stability: main_d changes only when main is loaded, so out_data stays stable while out_valid = 1 and out_ready = 0.
- Unused data: with CLR_DATA = 0, data under a cleared valid is don't-care. Verification must not compare out_data when out_valid = 0.

Test Plan:
- Reset and idle: assert rstn = 0 for 2 cycles with in_valid = 1, in_data = 32'hDEADBEEF.
  - Required: out_valid 0, out_data 0, occ 0 and in_ready 1 after the edge; nothing captured.
- Streaming: out_ready = 1, push 1, 2, 3, 4 on consecutive cycles.
  - Required: out_data is 1, 2, 3, 4 on the following consecutive cycles, occ stays 1, in_ready never drops.
- Stall and skid: push 0xA then 0xB while out_ready = 0.
  - Required: occ 2 and in_ready 0 on the cycle after 0xB; out_data holds 0xA.
  - Then raise out_ready: 0xA, then 0xB emitted on successive cycles; in_ready returns 1 after 0xA leaves.
- Flush priority: with occ = 2, assert flush = 1 with in_valid = 1, in_data = 0x55.
  - Required next cycle: out_valid 0, occ 0, in_ready 1, 0x55 never appears at out_data.
- Simultaneous accept and emit with occ = 1 (main holds 0x10): in_valid = 1, in_data = 0x20, out_ready = 1.
  - Required next cycle: out_data 0x20, occ 1, skid unused.
- Randomised backpressure: random in_valid and out_ready for 2000 cycles against a scoreboard queue.
  - Required: exact in-order match, no loss or duplication, occ always <= 2.
  - Assertions: in_ready == ~skid_v, and out_data is stable while stalled.
  - Repeat with W = 1 and CLR_DATA = 0.
